// File: rtl/mem_request_unit_if.sv
// rtl/mem_request_unit_if.sv - request/response and memory command bundle for mem_request_unit
// master: datapath and memory side; slave: the request unit.
interface mem_request_unit_if #(
    parameter int ramWidth = 8,
    parameter int addrSize = 8
);
    logic                reqValid;
    logic                reqWrite;
    logic                reqIndirect;
    logic [addrSize-1:0] reqAddr;
    logic [ramWidth-1:0] reqData;
    logic                reqReady;

    logic                rspValid;
    logic [ramWidth-1:0] rspData;
    logic                rspErr;

    logic                memStart;
    logic [1:0]          memCntrl;
    logic [addrSize-1:0] memAddr;
    logic [ramWidth-1:0] memDataIn;
    logic                memIsIndirect;
    logic [ramWidth-1:0] memDataOut;
    logic                memDataReady;

    modport master (
        output reqValid, reqWrite, reqIndirect, reqAddr, reqData,
        input  reqReady, rspValid, rspData, rspErr,
        input  memStart, memCntrl, memAddr, memDataIn, memIsIndirect,
        output memDataOut, memDataReady
    );

    modport slave (
        input  reqValid, reqWrite, reqIndirect, reqAddr, reqData,
        output reqReady, rspValid, rspData, rspErr,
        output memStart, memCntrl, memAddr, memDataIn, memIsIndirect,
        input  memDataOut, memDataReady
    );
endinterface

// File: rtl/mem_request_unit.sv
// rtl/mem_request_unit.sv - processor-side initiator for the memory start/cntrl/dataReady handshake
// One access in flight; command held from ISSUE until completion or drain, with a WAIT timeout.
module mem_request_unit #(
    parameter int ramWidth      = 8,
    parameter int addrSize      = 8,
    parameter int timeoutCycles = 255
) (
    input  logic              clk,
    input  logic              clrN,
    mem_request_unit_if.slave bus,
    output logic              busy
);
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BLANK,
        WAIT,
        RESP,
        DRAIN
    } stateT;

    localparam logic [1:0]  cntrlIdle  = 2'b00;
    localparam logic [1:0]  cntrlRead  = 2'b01;
    localparam logic [1:0]  cntrlWrite = 2'b10;
    localparam logic [15:0] lastCount  = 16'(timeoutCycles - 1);

    stateT               state;
    stateT               nextState;
    logic [15:0]         count;
    logic [1:0]          cmdCntrl;
    logic [addrSize-1:0] cmdAddr;
    logic [ramWidth-1:0] cmdData;
    logic                cmdIndirect;
    logic [ramWidth-1:0] rspDataQ;
    logic                rspErrQ;

    logic loadCmd;
    logic clearCmd;
    logic captureData;
    logic setErr;
    logic clearErr;
    logic clearCount;
    logic incCount;

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        loadCmd     = 1'b0;
        clearCmd    = 1'b0;
        captureData = 1'b0;
        setErr      = 1'b0;
        clearErr    = 1'b0;
        clearCount  = 1'b0;
        incCount    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.reqValid) begin
                    loadCmd   = 1'b1;
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                nextState = BLANK;
            end
            // A ready left high by the previous access is still visible here, so it is not sampled.
            BLANK: begin
                clearCount = 1'b1;
                nextState  = WAIT;
            end
            WAIT: begin
                incCount = 1'b1;
                if (bus.memDataReady) begin
                    clearErr    = 1'b1;
                    captureData = (cmdCntrl == cntrlRead);
                    nextState   = RESP;
                end else if (count == lastCount) begin
                    setErr    = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                if (rspErrQ) begin
                    nextState = DRAIN;
                end else begin
                    clearCmd  = 1'b1;
                    nextState = IDLE;
                end
            end
            // Late completion after a timeout is swallowed; the command stays up until it arrives.
            DRAIN: begin
                if (bus.memDataReady) begin
                    clearCmd  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            cmdCntrl    <= cntrlIdle;
            cmdAddr     <= '0;
            cmdData     <= '0;
            cmdIndirect <= 1'b0;
            count       <= '0;
            rspDataQ    <= '0;
            rspErrQ     <= 1'b0;
        end else begin
            if (loadCmd) begin
                cmdCntrl    <= bus.reqWrite ? cntrlWrite : cntrlRead;
                cmdAddr     <= bus.reqAddr;
                cmdData     <= bus.reqData;
                cmdIndirect <= bus.reqIndirect;
            end else if (clearCmd) begin
                cmdCntrl <= cntrlIdle;
            end
            if (clearCount) begin
                count <= '0;
            end else if (incCount) begin
                count <= count + 16'd1;
            end
            if (captureData) begin
                rspDataQ <= bus.memDataOut;
            end
            if (setErr) begin
                rspErrQ <= 1'b1;
            end else if (clearErr) begin
                rspErrQ <= 1'b0;
            end
        end
    end

    assign bus.reqReady      = (state == IDLE);
    assign bus.rspValid      = (state == RESP);
    assign bus.memStart      = (state == ISSUE);
    assign busy              = (state != IDLE);
    assign bus.rspData       = rspDataQ;
    assign bus.rspErr        = rspErrQ;
    assign bus.memCntrl      = cmdCntrl;
    assign bus.memAddr       = cmdAddr;
    assign bus.memDataIn     = cmdData;
    assign bus.memIsIndirect = cmdIndirect;
endmodule

// File: tb/tb_mem_request_unit.sv
// tb/tb_mem_request_unit.sv - scoreboard bench for mem_request_unit
// Memory model raises ready a set number of cycles after memStart and leaves it high until the next access.
module tb_mem_request_unit;
    localparam int TO = 16;

    logic clk  = 1'b0;
    logic clrN = 1'b0;
    logic busy;

    mem_request_unit_if #(.ramWidth(8), .addrSize(8)) bus ();

    mem_request_unit #(
        .ramWidth     (8),
        .addrSize     (8),
        .timeoutCycles(TO)
    ) dut (
        .clk  (clk),
        .clrN (clrN),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       err;
    } rspT;

    typedef struct {
        logic [1:0] cntrl;
        logic [7:0] addr;
        logic [7:0] dataIn;
        logic       ind;
    } cmdT;

    int   checks = 0;
    int   fails  = 0;
    int   cycle  = 0;
    rspT  rspQ[$];
    cmdT  cmdQ[$];
    cmdT  curCmd;
    int   startLog[$];
    int   lastRspCycle = 0;
    int   rspSeen = 0;
    int   rspPushed = 0;
    int   startsSeen = 0;
    int   startsExp = 0;
    int   memDelay = 0;
    logic [7:0] memArr [256];

    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // memory model: delay 0 means never completes
    int         mCyc;
    bit         mActive = 1'b0;
    bit         mWrite;
    int         mDelay;
    logic [7:0] mAddr;
    logic [7:0] mData;
    always @(negedge clk) begin
        if (!clrN) begin
            bus.memDataReady = 1'b0;
            bus.memDataOut   = 8'h00;
            mActive          = 1'b0;
        end else if (bus.memStart) begin
            mActive = 1'b1;
            mCyc    = 0;
            mDelay  = memDelay;
            mAddr   = bus.memAddr;
            mData   = bus.memDataIn;
            mWrite  = (bus.memCntrl == 2'b10);
        end else if (mActive) begin
            mCyc++;
            if (mCyc == 2) begin
                bus.memDataReady = 1'b0;
                bus.memDataOut   = 8'hFF;
            end
            if (mCyc == mDelay) begin
                bus.memDataReady = 1'b1;
                if (mWrite) begin
                    memArr[mAddr]  = mData;
                    bus.memDataOut = 8'hEE;
                end else begin
                    bus.memDataOut = memArr[mAddr];
                end
                mActive = 1'b0;
            end
        end
    end

    // monitor: scoreboard pop on rspValid, command hold while busy
    rspT e;
    always @(negedge clk) begin
        if (clrN) begin
            if (bus.memStart) begin
                startsSeen++;
                startLog.push_back(cycle);
                if (cmdQ.size() > 0) curCmd = cmdQ.pop_front();
            end
            if (bus.rspValid) begin
                rspSeen++;
                lastRspCycle = cycle;
                if (rspQ.size() == 0) begin
                    check("unexpected rspValid", 32'd1, 32'd0);
                end else begin
                    e = rspQ.pop_front();
                    check("rspData", 32'(bus.rspData), 32'(e.data));
                    check("rspErr", 32'(bus.rspErr), 32'(e.err));
                end
            end
            if (busy) begin
                check("cmd hold", 32'({bus.memCntrl, bus.memAddr, bus.memDataIn, bus.memIsIndirect, bus.reqReady}),
                      32'({curCmd.cntrl, curCmd.addr, curCmd.dataIn, curCmd.ind, 1'b0}));
            end else begin
                check("idle outputs", 32'({bus.memCntrl, bus.reqReady, bus.memStart, bus.rspValid}),
                      32'({2'b00, 1'b1, 1'b0, 1'b0}));
            end
        end
    end

    task automatic sendReq(input bit w, input bit ind, input logic [7:0] a, input logic [7:0] d,
                           input int dly, input bit expRsp, input logic [7:0] expData,
                           input bit expErr, input bit hold);
        int n = 0;
        memDelay        = dly;
        bus.reqWrite    = w;
        bus.reqIndirect = ind;
        bus.reqAddr     = a;
        bus.reqData     = d;
        bus.reqValid    = 1'b1;
        while (!bus.reqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("request accepted", 32'(bus.reqReady), 32'd1);
        cmdQ.push_back('{w ? 2'b10 : 2'b01, a, d, ind});
        startsExp++;
        if (expRsp) begin
            rspQ.push_back('{expData, expErr});
            rspPushed++;
        end
        @(negedge clk);
        if (!hold) bus.reqValid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic checkResetOutputs(input string name);
        check({name, " ctl"}, 32'({bus.reqReady, bus.rspValid, bus.rspErr, bus.memStart, busy,
                                   bus.memIsIndirect, bus.memCntrl}), 32'h80);
        check({name, " data"}, 32'({bus.memAddr, bus.memDataIn, bus.rspData}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.reqValid    = 1'b0;
        bus.reqWrite    = 1'b0;
        bus.reqIndirect = 1'b0;
        bus.reqAddr     = 8'h00;
        bus.reqData     = 8'h00;
        for (int i = 0; i < 256; i++) memArr[i] = 8'(i);
        memArr[8'h3C] = 8'hA5;
        memArr[8'h44] = 8'hC3;

        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        clrN = 1'b1;
        @(negedge clk);

        // plain read
        sendReq(1'b0, 1'b0, 8'h3C, 8'h00, 6, 1'b1, 8'hA5, 1'b0, 1'b0);
        waitIdle("read 3C done");
        check("one memStart", 32'(startsSeen), 32'd1);

        // write, then read with the write's ready still high
        sendReq(1'b1, 1'b0, 8'h10, 8'h5A, 4, 1'b1, 8'hA5, 1'b0, 1'b0);
        waitIdle("write done");
        check("ready left high", 32'(bus.memDataReady), 32'd1);
        sendReq(1'b0, 1'b0, 8'h10, 8'h00, 5, 1'b1, 8'h5A, 1'b0, 1'b0);
        waitIdle("read after write done");

        // indirect read
        sendReq(1'b0, 1'b1, 8'h44, 8'h00, 12, 1'b1, 8'hC3, 1'b0, 1'b0);
        waitIdle("indirect done");

        // minimum latency: ready already high in first WAIT
        sendReq(1'b0, 1'b0, 8'h3C, 8'h00, 1, 1'b1, 8'hA5, 1'b0, 1'b0);
        waitIdle("min latency done");
        check("min latency", 32'(lastRspCycle - startLog[$]), 32'd3);

        // ready on the last WAIT cycle: completion wins over timeout
        sendReq(1'b0, 1'b0, 8'h10, 8'h00, TO + 1, 1'b1, 8'h5A, 1'b0, 1'b0);
        waitIdle("simultaneous done");
        check("simultaneous latency", 32'(lastRspCycle - startLog[$]), 32'(TO + 2));

        // timeout, then late ready drained without a response
        sendReq(1'b0, 1'b0, 8'h3C, 8'h00, TO + 12, 1'b1, 8'h5A, 1'b1, 1'b0);
        waitIdle("drain done");
        check("timeout latency", 32'(lastRspCycle - startLog[$]), 32'(TO + 2));
        check("drain exit cycle", 32'(cycle - startLog[$]), 32'(TO + 13));
        check("late data discarded", 32'(bus.rspData), 32'h5A);

        // back-to-back with reqValid held
        sendReq(1'b0, 1'b0, 8'h3C, 8'h00, 1, 1'b1, 8'hA5, 1'b0, 1'b1);
        sendReq(1'b0, 1'b1, 8'h44, 8'h00, 1, 1'b1, 8'hC3, 1'b0, 1'b0);
        waitIdle("back-to-back done");
        check("back-to-back spacing", 32'(startLog[$] - startLog[$-1]), 32'd5);

        // reset in the middle of WAIT against a hung memory
        sendReq(1'b0, 1'b0, 8'h10, 8'h00, 0, 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("in wait before reset", 32'(busy), 32'd1);
        #1 clrN = 1'b0;
        #1;
        checkResetOutputs("mid-wait reset");
        cmdQ.delete();
        @(negedge clk);
        clrN = 1'b1;
        @(negedge clk);
        sendReq(1'b0, 1'b0, 8'h44, 8'h00, 3, 1'b1, 8'hC3, 1'b0, 1'b0);
        waitIdle("post-reset read done");

        repeat (3) @(negedge clk);
        check("scoreboard empty", 32'(rspQ.size()), 32'd0);
        check("response count", 32'(rspSeen), 32'(rspPushed));
        check("memStart count", 32'(startsSeen), 32'(startsExp));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/mem_request_unit.md
Name: mem_request_unit

Overview:
- Processor-side initiator for the memory subsystem (cache, cache controller, data RAM) and the requesting end of its start/cntrl/dataReady handshake.
- Accepts one load/store request at a time from the datapath control unit.
- Drives and holds the memory command until completion, then returns read data to the datapath.
- Guards against a hung memory with a timeout and drains late completions before accepting new work.

Parameters:
- ramWidth, 8, data word width; must match the memory subsystem.
- addrSize, 8, address width; must match the memory subsystem.
- timeoutCycles, 255, maximum cycles spent in WAIT before declaring an error; range 1..65535.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clrN  in  1  asynchronous, active-low reset.
- reqValid  in  1  datapath request present.
- reqWrite  in  1  1 = store, 0 = load.
- reqIndirect  in  1  request uses indirect addressing.
- reqAddr  in  addrSize  request address.
- reqData  in  ramWidth  store data.
- reqReady  out  1  unit can accept a request this cycle.
- rspValid  out  1  one-cycle pulse: response available.
- rspData  out  ramWidth  load data; held until the next response.
- rspErr  out  1  qualifies rspValid; 1 = timeout.
- memStart  out  1  one-cycle command pulse to memory.
- memCntrl  out  2  00 idle, 01 read, 10 write, 11 never driven.
- memAddr  out  addrSize  command address.
- memDataIn  out  ramWidth  command write data.
- memIsIndirect  out  1  indirect flag to memory.
- memDataOut  in  ramWidth  memory read data.
- memDataReady  in  1  memory completion; level signal, may remain high until the next memStart.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values (on clrN low, asynchronously):
  - state = IDLE; reqReady = 1.
  - rspValid, rspErr, memStart, busy, memIsIndirect = 0.
  - memCntrl = 00; memAddr, memDataIn, rspData = 0; timeout counter = 0.
- IDLE:
  - reqReady = 1.
  - On reqValid, register the command: memCntrl = reqWrite ? 10 : 01; memAddr = reqAddr; memDataIn = reqData; memIsIndirect = reqIndirect. Go to ISSUE.
  - reqReady drops in the cycle after acceptance.
- ISSUE: memStart = 1 for exactly this cycle; go to BLANK.
- BLANK:
  - memDataReady is ignored for exactly this one cycle, because a stale high from the previous access may still be present.
  - Clear the counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If memDataReady = 1: rspData = memDataOut for reads; rspData unchanged for writes. Go to RESP with rspErr = 0.
  - Else if counter == timeoutCycles-1: go to RESP with rspErr = 1, rspData unchanged.
  - If both conditions hold in the same cycle, completion wins (rspErr = 0).
- RESP:
  - rspValid = 1 for one cycle.
  - If rspErr = 0: memCntrl returns to 00; go to IDLE.
  - If rspErr = 1: memCntrl is held; go to DRAIN.
- DRAIN:
  - reqReady = 0; wait for memDataReady = 1.
  - The late data is discarded, with no rspValid.
  - Then memCntrl = 00; go to IDLE.
  - DRAIN has no timeout; only reset exits a permanently hung memory.
- Command hold: memCntrl, memAddr, memDataIn and memIsIndirect are held stable from ISSUE through WAIT/DRAIN exit. They change only in IDLE on acceptance.
- Latency: minimum accept-to-rspValid is 4 cycles (ISSUE, BLANK, WAIT with ready already high, RESP).
- Back-to-back requests: the earliest next acceptance is the cycle after RESP, giving a minimum of 5 cycles per access.
- reqValid held high while busy is not accepted and is not queued; the datapath must keep it asserted until it sees reqReady.
- Reset mid-access: every output immediately takes its reset value. Any in-flight memory operation is abandoned; the memory subsystem is reset by the same system reset.

Test Plan:
- Read: reqAddr = 8'h3C, reqWrite = 0; memory returns 8'hA5 after 6 cycles -> memStart pulses once; memCntrl = 01 and memAddr = 3C are stable throughout; rspValid pulses once with rspData = A5 and rspErr = 0; busy falls.
- Write then read, with memDataReady left high between the two accesses: write 8'h5A to 8'h10, then read 8'h10 -> the stale ready is ignored in BLANK; the read completes only on the new ready; rspData = 5A.
- Indirect read: reqIndirect = 1, memory ready at 12 cycles -> memIsIndirect = 1 for the whole access; correct data is returned; reqReady = 0 throughout.
- Timeout with timeoutCycles = 4 and no ready -> rspValid with rspErr = 1 after 4 WAIT cycles; reqReady stays 0 in DRAIN. A late ready at +10 cycles yields no second rspValid; the unit then returns to IDLE.
- Simultaneous events: ready arrives exactly on the last WAIT cycle -> rspErr = 0 with valid data. Separately, a back-to-back request spacing of 5 cycles is verified.
- Reset: assert clrN = 0 during WAIT -> all outputs at reset values in the same cycle; after release the first request completes normally.
